// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-bus accesses, formats store lanes,
// extracts and extends load data, and stalls the pipeline until the access
// completes, is abandoned by timeout, or is rejected as misaligned.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        stall_out,
    output logic [31:0] read_data_out,
    output logic        misaligned_out,
    output logic        bus_err_out,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter value on which the last permitted BUSY cycle runs.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;

    logic        op;
    logic        mis;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] ld_data;

    // Pick the addressed lane of the returned word and extend it to 32 bits.
    function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                             input logic [1:0]  a,
                                             input logic [1:0]  sz,
                                             input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {a, 3'b000});
        h = a[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   fmt_load = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   fmt_load = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: fmt_load = word;
        endcase
    endfunction

    assign op  = mem_read_in | mem_write_in;
    assign mis = ((size_in == 2'b01) & addr_in[0]) |
                 (size_in[1] & (addr_in[1:0] != 2'b00));

    assign misaligned_out = op & mis & (state_q == ST_IDLE);
    assign stall_out      = op & ~mis & (state_q != ST_DONE);

    // Store lane replication and byte enables; loads always enable all lanes.
    always_comb begin
        st_wdata = store_data_in;
        st_be    = 4'b1111;
        if (mem_write_in) begin
            case (size_in)
                2'b00: begin
                    st_wdata = {4{store_data_in[7:0]}};
                    st_be    = 4'b0001 << addr_in[1:0];
                end
                2'b01: begin
                    st_wdata = {2{store_data_in[15:0]}};
                    st_be    = addr_in[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    st_wdata = store_data_in;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    assign ld_data = fmt_load(bus_rdata, addr_in[1:0], size_in, unsigned_in);

    // Access sequencing: IDLE launches, BUSY waits for ack or timeout, DONE releases.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (op && !mis) begin
                    req_d   = 1'b1;
                    we_d    = mem_write_in;
                    addr_d  = {addr_in[31:2], 2'b00};
                    wdata_d = st_wdata;
                    be_d    = st_be;
                    cnt_d   = 8'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    req_d   = 1'b0;
                    rdata_d = mem_write_in ? 32'd0 : ld_data;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bus registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign read_data_out = rdata_q;
    assign bus_err_out   = err_q;
    assign bus_req       = req_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign bus_be        = be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu with a short timeout.
module tb_mem_stage_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_in, mem_write_in, unsigned_in;
    logic [1:0]  size_in;
    logic [31:0] addr_in, store_data_in;
    logic        stall_out, misaligned_out, bus_err_out;
    logic [31:0] read_data_out;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mem_stage_lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .size_in(size_in), .unsigned_in(unsigned_in),
        .addr_in(addr_in), .store_data_in(store_data_in),
        .stall_out(stall_out), .read_data_out(read_data_out),
        .misaligned_out(misaligned_out), .bus_err_out(bus_err_out),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        if (sz == 2'b00) return uns ? 32'(b) : 32'($signed(b));
        if (sz == 2'b01) return uns ? 32'(h) : 32'($signed(h));
        return w;
    endfunction

    // d = number of BUSY cycles before the ack cycle; d >= TMO means no ack.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                             input int d, input logic [31:0] rdata,
                             input logic [31:0] e_wdata, input logic [3:0] e_be);
        exp_t e, got;
        int   stalls, busy, reqs;
        bit   done;
        e.err    = (d >= TMO);
        e.data   = (e.err || wr) ? 32'd0 : model_load(rdata, addr, sz, uns);
        e.stalls = 1 + ((d + 1 < TMO) ? d + 1 : TMO);
        sb.push_back(e);

        @(negedge clk);
        mem_read_in = rd; mem_write_in = wr; size_in = sz;
        unsigned_in = uns; addr_in = addr; store_data_in = sd;
        #1;
        chk("idle_stall", 32'(stall_out), 32'd1);
        chk("idle_mis", 32'(misaligned_out), 32'd0);
        stalls = 1; busy = 0; reqs = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (!stall_out) done = 1;
            else begin
                stalls++;
                if (bus_req) reqs++;
                if (busy == 0) begin
                    chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
                    chk("bus_be", 32'(bus_be), 32'(e_be));
                    chk("bus_we", 32'(bus_we), 32'(wr));
                    if (wr) chk("bus_wdata", bus_wdata, e_wdata);
                end
                if (busy == d) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdata;
                end
                busy++;
            end
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        chk("sb_nonempty", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("rdata", read_data_out, got.data);
            chk("err", 32'(bus_err_out), 32'(got.err));
            chk("stalls", 32'(stalls), 32'(got.stalls));
            chk("req_cycles", 32'(reqs), 32'(got.stalls - 1));
        end
        chk("done_req", 32'(bus_req), 32'd0);
        mem_read_in = 1'b0; mem_write_in = 1'b0;
        @(negedge clk);
        chk("err_clr", 32'(bus_err_out), 32'd0);
        chk("idle_nostall", 32'(stall_out), 32'd0);
    endtask

    initial begin
        reset = 1'b1; mem_read_in = 0; mem_write_in = 0; size_in = 2'b10;
        unsigned_in = 0; addr_in = 0; store_data_in = 0; bus_ack = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_rdata", read_data_out, 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_err", 32'(bus_err_out), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        reset = 1'b0;

        // Ack while idle is ignored.
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        @(negedge clk); bus_ack = 1'b0;
        chk("idle_ack_req", 32'(bus_req), 32'd0);
        chk("idle_ack_rdata", read_data_out, 32'd0);

        do_access(1, 0, 2'b10, 0, 32'h100, 0, 0, 32'hDEADBEEF, 0, 4'b1111);
        do_access(1, 0, 2'b00, 0, 32'h103, 0, 0, 32'h8000_0000, 0, 4'b1111);
        do_access(1, 0, 2'b00, 1, 32'h103, 0, 1, 32'h8000_0000, 0, 4'b1111);
        do_access(0, 1, 2'b01, 0, 32'h202, 32'hABCD1234, 2, 0, 32'h1234_1234, 4'b1100);
        do_access(1, 0, 2'b01, 0, 32'h206, 0, 0, 32'h9ABC_0011, 0, 4'b1111);
        do_access(1, 0, 2'b01, 1, 32'h204, 0, 0, 32'h0000_F00D, 0, 4'b1111);
        do_access(1, 1, 2'b00, 0, 32'h301, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 4'b0010);
        do_access(0, 1, 2'b11, 0, 32'h400, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 4'b1111);
        do_access(1, 0, 2'b10, 0, 32'h500, 0, 99, 32'h1111_1111, 0, 4'b1111);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, w;
            logic [1:0]  s;
            s = 2'($urandom_range(0, 2));
            a = {$urandom_range(0, 255), 2'b00} | ((s == 2'b00) ? 32'($urandom_range(0, 3)) :
                (s == 2'b01) ? 32'(2 * $urandom_range(0, 1)) : 32'd0);
            w = $urandom;
            do_access(1, 0, s, 1'($urandom_range(0, 1)), a, 0, $urandom_range(0, 2), w, 0, 4'b1111);
        end

        // Misaligned word load: fault flagged, no stall, no bus request.
        @(negedge clk);
        mem_read_in = 1; size_in = 2'b10; addr_in = 32'h102;
        #1;
        chk("mis_flag", 32'(misaligned_out), 32'd1);
        chk("mis_stall", 32'(stall_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mis_noreq", 32'(bus_req), 32'd0);
        end
        mem_read_in = 0;

        // Reset in the second BUSY cycle abandons the access.
        do_access(1, 0, 2'b10, 0, 32'h600, 0, 0, 32'h1234_5678, 0, 4'b1111);
        @(negedge clk);
        mem_read_in = 1; size_in = 2'b10; addr_in = 32'h700; unsigned_in = 0;
        @(negedge clk);
        chk("rb_busy1_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rb_req", 32'(bus_req), 32'd0);
        chk("rb_rdata", read_data_out, 32'd0);
        chk("rb_stall", 32'(stall_out), 32'd1);
        reset = 1'b0; mem_read_in = 0;
        do_access(1, 0, 2'b10, 0, 32'h704, 0, 1, 32'h0BAD_F00D, 0, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit for the MEM stage of the 5-stage pipeline. It sits between the EX/MEM register outputs and the data-memory bus. It issues bus requests, formats store byte lanes and extracts/extends load data. It stalls the pipeline until the bus responds and supplies the load result captured by the MEM/WB register.

Parameters:
TIMEOUT, 255, BUSY-state cycles without bus_ack before the access is abandoned (1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
mem_read_in  input  1  load request from EX/MEM
mem_write_in  input  1  store request from EX/MEM; wins over mem_read_in if both high
size_in  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
unsigned_in  input  1  1 = zero-extend loads, 0 = sign-extend
addr_in  input  32  byte address (ALU result)
store_data_in  input  32  store data, value in low bits
stall_out  output  1  hold PC, IF/ID, ID/EX, EX/MEM and MEM/WB
read_data_out  output  32  formatted load data, registered
misaligned_out  output  1  combinational alignment fault, no bus access made
bus_err_out  output  1  high in DONE when the access timed out
bus_req  output  1  registered request, held until ack
bus_we  output  1  registered, 1 = write
bus_addr  output  32  registered, {addr_in[31:2],2'b00}
bus_wdata  output  32  registered, lane-replicated store data
bus_be  output  4  registered byte enables
bus_ack  input  1  single-cycle acknowledge from memory
bus_rdata  input  32  read word, valid when bus_ack=1

Behaviour:
- Reset values: state IDLE; read_data_out 0; bus_req 0; bus_we 0; bus_addr 0; bus_wdata 0; bus_be 0; bus_err_out 0; timeout counter 0.
- op = mem_read_in | mem_write_in.
- mis = (size=01 & addr_in[0]) | (size in {10,11} & addr_in[1:0]!=0).
- misaligned_out = op & mis & state==IDLE.
- stall_out = op & ~mis & state!=DONE. It is combinational and high in the IDLE cycle that detects the op.
- FSM IDLE:
  - On op & ~mis: load bus_* registers, set bus_req=1, clear counter, go to BUSY.
  - Otherwise remain in IDLE; read_data_out holds its value.
  - A misaligned op gives no bus activity and no stall.
- FSM BUSY:
  - bus_req is held high with stable addr/data/be.
  - On bus_ack=1: drop bus_req; for a load, write formatted bus_rdata to read_data_out; for a store, write 0. Go to DONE.
  - Else if counter==TIMEOUT-1: drop bus_req, read_data_out=0, set bus_err_out=1, go to DONE.
  - Else increment the counter.
- FSM DONE:
  - stall_out=0, so the pipeline advances at the end of this cycle and MEM/WB captures read_data_out.
  - Next state IDLE; bus_err_out clears on leaving DONE.
- Inputs are held stable by the stall from IDLE through DONE.
- Minimum occupancy is 3 cycles (ack in the first BUSY cycle): 2 stall cycles.
- bus_ack in IDLE or DONE is ignored.
- Store formatting:
  - Byte: wdata={4{sd[7:0]}}, be=0001<<addr[1:0].
  - Half: wdata={2{sd[15:0]}}, be=0011 (addr[1]=0) or 1100.
  - Word: wdata=sd, be=1111.
- Load formatting:
  - Byte: lane addr[1:0] of bus_rdata, extended per unsigned_in.
  - Half: lane addr[1] (upper when 1), extended per unsigned_in.
  - Word: full word.
  - bus_be=1111 for all loads.
- Both read and write asserted: performed as a store, read_data_out=0.
- Reset mid-transaction: next edge returns to IDLE with bus_req=0. The access is abandoned and the memory side must tolerate a withdrawn request.

Test Plan:
- Word load addr 0x100, ack in the first BUSY cycle with rdata 0xDEADBEEF:
  - bus_req=1 with bus_addr 0x100, be 1111.
  - stall_out high for 2 cycles.
  - read_data_out=0xDEADBEEF in DONE.
- Signed byte load at 0x103, rdata 0x80000000:
  - read_data_out=0xFFFFFF80; with unsigned_in=1, 0x00000080.
- Halfword store 0xABCD1234 to 0x202:
  - bus_addr 0x200, wdata 0x12341234, be 1100, bus_we=1.
  - ack after 3 cycles gives 4 stall cycles total.
- Word load at 0x102: misaligned_out=1, stall_out=0, bus_req never asserts.
- TIMEOUT=4, no ack:
  - bus_req high for 4 cycles then drops.
  - bus_err_out=1 and read_data_out=0 in DONE; state returns to IDLE.
- reset asserted in the second BUSY cycle:
  - Next cycle bus_req=0, stall_out follows IDLE rules, read_data_out=0.
  - A following load completes normally.
